ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: the send side of the PS/2 link, complementing the receive-only keyboard/mouse decoders.

---
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Open-drain outputs: *_oe_o=1 pulls the pad low, otherwise the pad floats high.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 2500,
    parameter int START_TIMEOUT_CYCLES = 375000,
    parameter int XFER_TIMEOUT_CYCLES  = 50000,
    parameter int FILTER_LEN           = 8
) (
    input  logic       clk_cpu,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       rdy_o,
    output logic       done_o,
    output logic [1:0] err_o,
    input  logic       ps2clk_i,
    input  logic       ps2dat_i,
    output logic       ps2clk_oe_o,
    output logic       ps2dat_oe_o
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int ST_W  = $clog2(START_TIMEOUT_CYCLES + 1);
    localparam int XF_W  = $clog2(XFER_TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [XF_W-1:0]  XF_LAST  = XF_W'(XFER_TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_INHIBIT    = 4'd1;
    localparam logic [3:0] S_REQ        = 4'd2;
    localparam logic [3:0] S_WAIT_FIRST = 4'd3;
    localparam logic [3:0] S_BITS       = 4'd4;
    localparam logic [3:0] S_ACK        = 4'd5;
    localparam logic [3:0] S_WAIT_REL   = 4'd6;
    localparam logic [3:0] S_DONE       = 4'd7;
    localparam logic [3:0] S_ERR        = 4'd8;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]       sync1_q, sync2_q, filt_q;
    logic [FLT_W-1:0] fcnt_q [2];
    logic [1:0]       flip;
    logic             fall;

    always_comb begin
        flip = '0;
        for (int i = 0; i < 2; i++) begin
            flip[i] = (sync2_q[i] != filt_q[i]) && (fcnt_q[i] == FLT_LAST);
        end
    end

    // The filtered clock drops on this very edge.
    assign fall = flip[0] & ~sync2_q[0];

    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            sync1_q <= {ps2dat_i, ps2clk_i};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (flip[i]) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic [3:0]       state_q, state_d;
    logic [9:0]       shreg_q, shreg_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic             dat_oe_q, dat_oe_d;
    logic [1:0]       err_q, err_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [ST_W-1:0]  st_q, st_d;
    logic [XF_W-1:0]  xf_q, xf_d;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        dat_oe_d = dat_oe_q;
        err_d    = err_q;
        inh_d    = inh_q;
        st_d     = st_q;
        xf_d     = xf_q;
        case (state_q)
            S_IDLE: begin
                dat_oe_d = 1'b0;
                if (start_i) begin
                    shreg_d  = {1'b1, ~^data_i, data_i};
                    err_d    = 2'b00;
                    bitcnt_d = 4'd0;
                    inh_d    = '0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                inh_d = inh_q + 1'b1;
                if (inh_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    st_d     = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                st_d    = '0;
                state_d = S_WAIT_FIRST;
            end
            S_WAIT_FIRST: begin
                st_d = st_q + 1'b1;
                if (st_q == ST_LAST) begin
                    err_d    = 2'b01;
                    dat_oe_d = 1'b0;
                    state_d  = S_ERR;
                end else if (fall) begin
                    dat_oe_d = ~shreg_q[0];
                    shreg_d  = {1'b0, shreg_q[9:1]};
                    bitcnt_d = 4'd1;
                    xf_d     = '0;
                    state_d  = S_BITS;
                end
            end
            S_BITS, S_ACK, S_WAIT_REL: begin
                xf_d = xf_q + 1'b1;
                // A timeout overrides a clock fall landing on the same cycle.
                if (xf_q == XF_LAST) begin
                    err_d    = 2'b10;
                    dat_oe_d = 1'b0;
                    state_d  = S_ERR;
                end else if (state_q == S_BITS) begin
                    if (fall) begin
                        dat_oe_d = ~shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[9:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end else if (state_q == S_ACK) begin
                    dat_oe_d = 1'b0;
                    if (fall) begin
                        if (filt_q[1]) begin
                            err_d   = 2'b11;
                            state_d = S_ERR;
                        end else begin
                            state_d = S_WAIT_REL;
                        end
                    end
                end else if (filt_q == 2'b11) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            dat_oe_q <= 1'b0;
            err_q    <= 2'b00;
            inh_q    <= '0;
            st_q     <= '0;
            xf_q     <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            dat_oe_q <= dat_oe_d;
            err_q    <= err_d;
            inh_q    <= inh_d;
            st_q     <= st_d;
            xf_q     <= xf_d;
        end
    end

    assign rdy_o       = (state_q == S_IDLE);
    assign done_o      = (state_q == S_DONE) || (state_q == S_ERR);
    assign err_o       = err_q;
    assign ps2clk_oe_o = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign ps2dat_oe_o = dat_oe_q && ((state_q == S_REQ) || (state_q == S_WAIT_FIRST)
                                      || (state_q == S_BITS));

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
// Timing parameters are scaled down so every scenario stays short.
module tb_ps2_host_tx;

    localparam int INH   = 250;
    localparam int ST    = 3000;
    localparam int XF    = 5000;
    localparam int FL    = 8;
    localparam int LOW   = 100;
    localparam int HIGH  = 100;
    localparam int BOUND = 20000;

    localparam int M_NORMAL = 0;
    localparam int M_NOACK  = 1;
    localparam int M_NOCLK  = 2;
    localparam int M_STOP4  = 3;
    localparam int M_GLITCH = 4;
    localparam int M_IGN    = 5;

    logic       clk_cpu = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] data_i  = 8'h00;
    logic       rdy_o, done_o;
    logic [1:0] err_o;
    logic       ps2clk_i, ps2dat_i, ps2clk_oe_o, ps2dat_oe_o;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    assign ps2clk_i = dev_clk & ~ps2clk_oe_o;
    assign ps2dat_i = dev_dat & ~ps2dat_oe_o;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(ST),
        .XFER_TIMEOUT_CYCLES (XF),
        .FILTER_LEN          (FL)
    ) dut (
        .clk_cpu    (clk_cpu),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .data_i     (data_i),
        .rdy_o      (rdy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .ps2clk_i   (ps2clk_i),
        .ps2dat_i   (ps2dat_i),
        .ps2clk_oe_o(ps2clk_oe_o),
        .ps2dat_oe_o(ps2dat_oe_o)
    );

    always #20 clk_cpu = ~clk_cpu;

    typedef struct {
        logic [1:0] err;
        logic [9:0] frame;
        logic       chk;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         done_seen = 0;
    int         fall_cnt = 0;
    logic [9:0] frame_cap = '0;
    logic       abort    = 1'b0;
    logic       dev_busy = 1'b0;
    int         t_inh, t_req, t_rel, t_ff, t_done;
    logic       first_pending = 1'b0;
    logic       clk_oe_p = 1'b0;
    logic       dat_oe_p = 1'b0;
    logic       done_p   = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    always @(posedge clk_cpu) cyc <= cyc + 1;

    // Edge timestamps and scoreboard pop, sampled mid-cycle.
    always @(negedge clk_cpu) begin
        if (!clk_oe_p && ps2clk_oe_o) t_inh = cyc;
        if (!dat_oe_p && ps2dat_oe_o && ps2clk_oe_o) t_req = cyc;
        if (clk_oe_p && !ps2clk_oe_o) begin
            t_rel = cyc;
            first_pending = 1'b1;
        end
        if (first_pending && dat_oe_p && !ps2dat_oe_o && !ps2clk_oe_o && !done_o) begin
            t_ff = cyc;
            first_pending = 1'b0;
        end
        if (done_p) check("rdy_after_done", rdy_o, 1);
        if (done_o === 1'b1) begin
            t_done = cyc;
            first_pending = 1'b0;
            check("pending_exp", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("err", err_o, mon_e.err);
                check("clk_oe_at_done", ps2clk_oe_o, 0);
                check("dat_oe_at_done", ps2dat_oe_o, 0);
                if (mon_e.chk) check("frame", frame_cap, mon_e.frame);
            end
            done_seen++;
        end
        done_p   = (done_o === 1'b1);
        clk_oe_p = ps2clk_oe_o;
        dat_oe_p = ps2dat_oe_o;
    end

    task automatic dev_wait(input int n);
        for (int i = 0; i < n; i++) begin
            if (abort) break;
            @(negedge clk_cpu);
        end
    endtask

    // Device: waits for a host request, then clocks 11 bits and acks.
    task automatic dev_run(input int mode);
        int n;
        dev_busy = 1'b1;
        n = 0;
        while (!(ps2clk_oe_o === 1'b0 && ps2dat_oe_o === 1'b1) && n < BOUND && !abort) begin
            @(negedge clk_cpu);
            n++;
        end
        if (mode != M_NOCLK) begin
            dev_wait(50);
            for (int b = 1; b <= 11; b++) begin
                if (abort || (mode == M_STOP4 && b == 5)) break;
                if (b == 11 && mode != M_NOACK) begin
                    dev_dat = 1'b0;
                    dev_wait(20);
                end
                dev_clk = 1'b0;
                fall_cnt = b;
                dev_wait(LOW);
                if (b <= 10) frame_cap[b-1] = ps2dat_i;
                dev_clk = 1'b1;
                if (b == 11) dev_dat = 1'b1;
                if (mode == M_GLITCH && b == 3) begin
                    dev_wait(30);
                    dev_clk = 1'b0;
                    dev_wait(3);
                    dev_clk = 1'b1;
                    dev_wait(HIGH - 33);
                end else begin
                    dev_wait(HIGH);
                end
            end
        end
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        dev_busy = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int mode);
        exp_t e;
        int   seen;
        int   n;
        e.err   = (mode == M_NOCLK) ? 2'b01 : (mode == M_STOP4) ? 2'b10 :
                  (mode == M_NOACK) ? 2'b11 : 2'b00;
        e.frame = {1'b1, ~^d, d};
        e.chk   = (mode != M_NOCLK) && (mode != M_STOP4);
        exp_q.push_back(e);
        frame_cap = '0;
        fall_cnt  = 0;
        abort     = 1'b0;
        seen      = done_seen;
        @(negedge clk_cpu);
        check("rdy_before", rdy_o, 1);
        start_i = 1'b1;
        data_i  = d;
        @(negedge clk_cpu);
        start_i = 1'b0;
        data_i  = 8'h00;
        check("err_cleared", err_o, 0);
        check("rdy_busy", rdy_o, 0);
        fork
            dev_run(mode);
            begin
                n = 0;
                while (done_seen == seen && n < BOUND) begin
                    @(negedge clk_cpu);
                    n++;
                end
                check("done_count", done_seen - seen, 1);
            end
            begin
                if (mode == M_IGN) begin
                    for (int k = 0; k < BOUND && fall_cnt < 3; k++) @(negedge clk_cpu);
                    check("reached_bits", fall_cnt >= 3, 1);
                    @(negedge clk_cpu);
                    check("rdy_in_bits", rdy_o, 0);
                    start_i = 1'b1;
                    @(negedge clk_cpu);
                    start_i = 1'b0;
                end
            end
        join
        if (mode == M_NORMAL) check("inhibit_len", t_req - t_inh, INH);
        if (mode == M_NOCLK)  check("start_timeout", t_done - t_rel, ST);
        if (mode == M_STOP4)  check("xfer_timeout", t_done - t_ff, XF);
        repeat (20) @(negedge clk_cpu);
    endtask

    initial begin
        repeat (4) @(negedge clk_cpu);
        rst_n = 1'b1;
        @(negedge clk_cpu);
        check("rst_rdy", rdy_o, 1);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_clk_oe", ps2clk_oe_o, 0);
        check("rst_dat_oe", ps2dat_oe_o, 0);

        send(8'hED, M_NORMAL);
        send(8'hF4, M_NORMAL);
        send(8'h55, M_NOCLK);
        send(8'hED, M_NOACK);
        repeat (20) @(negedge clk_cpu);
        check("err_held", err_o, 2'b11);
        send(8'hED, M_STOP4);
        send(8'h3C, M_GLITCH);
        send(8'h81, M_IGN);

        // Reset in the middle of the bit phase.
        frame_cap = '0;
        fall_cnt  = 0;
        abort     = 1'b0;
        @(negedge clk_cpu);
        start_i = 1'b1;
        data_i  = 8'hED;
        @(negedge clk_cpu);
        start_i = 1'b0;
        fork
            dev_run(M_NORMAL);
        join_none
        for (int k = 0; k < BOUND && fall_cnt < 4; k++) @(negedge clk_cpu);
        check("rst_reached_bits", fall_cnt >= 4, 1);
        rst_n = 1'b0;
        abort = 1'b1;
        @(negedge clk_cpu);
        check("midrst_clk_oe", ps2clk_oe_o, 0);
        check("midrst_dat_oe", ps2dat_oe_o, 0);
        check("midrst_rdy", rdy_o, 1);
        check("midrst_err", err_o, 0);
        rst_n = 1'b1;
        for (int k = 0; k < BOUND && dev_busy; k++) @(negedge clk_cpu);
        check("dev_idle", dev_busy, 0);
        repeat (50) @(negedge clk_cpu);
        send(8'hED, M_NORMAL);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
